// File: rtl/dmem_map_pkg.sv
// Shared data-memory map: regions, bus FSM states, default
// base/size constants for every decoder of the data port.
package dmem_map_pkg;

  typedef enum logic [1:0] {
    REG_NONE,
    REG_SRAM,
    REG_CTRL,
    REG_UART
  } region_e;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    STROBE,
    DONE,
    ERROR
  } state_e;

  localparam int          DEF_NUM_SRAM       = 2;
  localparam logic [31:0] DEF_SRAM_BASE      = 32'h1000_0000;
  localparam int          DEF_SRAM_SIZE_LOG2 = 26;
  localparam logic [31:0] DEF_CTRL_BASE      = 32'h44E1_0000;
  localparam int          DEF_CTRL_SIZE_LOG2 = 13;
  localparam logic [31:0] DEF_UART_BASE      = 32'h4802_2000;
  localparam int          DEF_UART_SIZE_LOG2 = 12;
  localparam int          DEF_SRAM_WAIT      = 1;
  localparam int          DEF_PERIPH_WAIT    = 0;

  function automatic int bank_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dmem_region_decode.sv
// Combinational address decode into SRAM bank, Control
// Module or UART1 window using aligned base compares.
module dmem_region_decode
  import dmem_map_pkg::*;
#(
  parameter int          AW             = 32,
  parameter int          NUM_SRAM       = DEF_NUM_SRAM,
  parameter int          BW             = bank_w(NUM_SRAM),
  parameter logic [AW-1:0] SRAM_BASE    = DEF_SRAM_BASE,
  parameter int          SRAM_SIZE_LOG2 = DEF_SRAM_SIZE_LOG2,
  parameter logic [AW-1:0] CTRL_BASE    = DEF_CTRL_BASE,
  parameter int          CTRL_SIZE_LOG2 = DEF_CTRL_SIZE_LOG2,
  parameter logic [AW-1:0] UART_BASE    = DEF_UART_BASE,
  parameter int          UART_SIZE_LOG2 = DEF_UART_SIZE_LOG2
) (
  input  logic [AW-1:0] i_addr,
  output region_e       o_region,
  output logic [BW-1:0] o_bank,
  output logic          o_hit
);

  logic [AW-1:0] w_off;
  logic [AW-1:0] w_idx;
  logic          w_sram;
  logic          w_ctrl;
  logic          w_uart;

  // Below-base addresses wrap to a huge index and miss.
  assign w_off  = i_addr - SRAM_BASE;
  assign w_idx  = w_off >> SRAM_SIZE_LOG2;
  assign w_sram = w_idx < AW'(NUM_SRAM);

  assign w_ctrl = i_addr[AW-1:CTRL_SIZE_LOG2]
               == CTRL_BASE[AW-1:CTRL_SIZE_LOG2];
  assign w_uart = i_addr[AW-1:UART_SIZE_LOG2]
               == UART_BASE[AW-1:UART_SIZE_LOG2];

  always_comb begin
    o_region = REG_NONE;
    unique case (1'b1)
      w_sram:  o_region = REG_SRAM;
      w_ctrl:  o_region = REG_CTRL;
      w_uart:  o_region = REG_UART;
      default: o_region = REG_NONE;
    endcase
  end

  assign o_bank = w_idx[BW-1:0];
  assign o_hit  = o_region != REG_NONE;

endmodule

// File: rtl/data_memory_bus_ctrl.sv
// Data-port bus controller: request/ready FSM driving
// per-bank SRAM strobes and peripheral selects.
module data_memory_bus_ctrl
  import dmem_map_pkg::*;
#(
  parameter int          AW             = 32,
  parameter int          NUM_SRAM       = DEF_NUM_SRAM,
  parameter logic [AW-1:0] SRAM_BASE    = DEF_SRAM_BASE,
  parameter int          SRAM_SIZE_LOG2 = DEF_SRAM_SIZE_LOG2,
  parameter logic [AW-1:0] CTRL_BASE    = DEF_CTRL_BASE,
  parameter int          CTRL_SIZE_LOG2 = DEF_CTRL_SIZE_LOG2,
  parameter logic [AW-1:0] UART_BASE    = DEF_UART_BASE,
  parameter int          UART_SIZE_LOG2 = DEF_UART_SIZE_LOG2,
  parameter int          SRAM_WAIT      = DEF_SRAM_WAIT,
  parameter int          PERIPH_WAIT    = DEF_PERIPH_WAIT
) (
  input  logic                clk,
  input  logic                RESET,
  input  logic                req,
  input  logic [AW-1:0]       address,
  input  logic                read,
  input  logic                write,
  output logic                ready,
  output logic                err,
  output logic                busy,
  output logic [NUM_SRAM-1:0] CE,
  output logic [NUM_SRAM-1:0] OE,
  output logic [NUM_SRAM-1:0] WE,
  output logic                Control_Module,
  output logic                UART1
);

  localparam int BW = bank_w(NUM_SRAM);

  state_e        r_state, w_state_n;
  region_e       r_region, w_region_n, w_dec_region;
  logic [BW-1:0] r_bank, w_bank_n, w_dec_bank;
  logic          r_wr, w_wr_n;
  logic [3:0]    r_cnt, w_cnt_n;
  logic          w_hit;

  logic [NUM_SRAM-1:0] w_oh;
  logic                w_sel;
  logic                w_stb;
  logic                w_sram;

  dmem_region_decode #(
    .AW             (AW),
    .NUM_SRAM       (NUM_SRAM),
    .BW             (BW),
    .SRAM_BASE      (SRAM_BASE),
    .SRAM_SIZE_LOG2 (SRAM_SIZE_LOG2),
    .CTRL_BASE      (CTRL_BASE),
    .CTRL_SIZE_LOG2 (CTRL_SIZE_LOG2),
    .UART_BASE      (UART_BASE),
    .UART_SIZE_LOG2 (UART_SIZE_LOG2)
  ) u_dec (
    .i_addr   (address),
    .o_region (w_dec_region),
    .o_bank   (w_dec_bank),
    .o_hit    (w_hit)
  );

  always_comb begin
    w_state_n  = r_state;
    w_region_n = r_region;
    w_bank_n   = r_bank;
    w_wr_n     = r_wr;
    w_cnt_n    = r_cnt;
    unique case (r_state)
      IDLE: begin
        if (req) begin
          if (w_hit && (read ^ write)) begin
            w_state_n  = SETUP;
            w_region_n = w_dec_region;
            w_bank_n   = w_dec_bank;
            w_wr_n     = write;
          end else begin
            w_state_n = ERROR;
          end
        end
      end
      SETUP: begin
        w_state_n = STROBE;
        w_cnt_n   = (r_region == REG_SRAM)
                  ? 4'(SRAM_WAIT) : 4'(PERIPH_WAIT);
      end
      STROBE: begin
        if (r_cnt != 4'd0) w_cnt_n = r_cnt - 4'd1;
        else               w_state_n = DONE;
      end
      DONE:    w_state_n = IDLE;
      ERROR:   w_state_n = IDLE;
      default: w_state_n = IDLE;
    endcase
  end

  always_comb begin
    w_oh = '0;
    for (int i = 0; i < NUM_SRAM; i++)
      w_oh[i] = (w_bank_n == BW'(i));
  end

  // Outputs are registered from the next state so they
  // line up with the state they belong to.
  assign w_sel  = (w_state_n == SETUP) || (w_state_n == STROBE);
  assign w_stb  = w_state_n == STROBE;
  assign w_sram = w_region_n == REG_SRAM;

  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      r_state        <= IDLE;
      r_region       <= REG_NONE;
      r_bank         <= '0;
      r_wr           <= 1'b0;
      r_cnt          <= '0;
      ready          <= 1'b0;
      err            <= 1'b0;
      busy           <= 1'b0;
      CE             <= '0;
      OE             <= '0;
      WE             <= '0;
      Control_Module <= 1'b0;
      UART1          <= 1'b0;
    end else begin
      r_state        <= w_state_n;
      r_region       <= w_region_n;
      r_bank         <= w_bank_n;
      r_wr           <= w_wr_n;
      r_cnt          <= w_cnt_n;
      ready          <= (w_state_n == DONE)
                     || (w_state_n == ERROR);
      err            <= w_state_n == ERROR;
      busy           <= w_state_n != IDLE;
      CE             <= (w_sel && w_sram) ? w_oh : '0;
      OE             <= (w_stb && w_sram && !w_wr_n)
                      ? w_oh : '0;
      WE             <= (w_stb && w_sram && w_wr_n)
                      ? w_oh : '0;
      Control_Module <= w_sel && (w_region_n == REG_CTRL);
      UART1          <= w_sel && (w_region_n == REG_UART);
    end
  end

endmodule

// File: tb/tb_data_memory_bus_ctrl.sv
// Directed bench for data_memory_bus_ctrl (2-bank instance
// plus a 3-bank instance for the top-bank boundary).
module tb_data_memory_bus_ctrl;

  logic        clk = 1'b0;
  logic        RESET;
  logic        req;
  logic [31:0] address;
  logic        read;
  logic        write;

  logic       ready, err, busy, cm, ua;
  logic [1:0] ce, oe, we;
  logic       ready3, err3, busy3, cm3, ua3;
  logic [2:0] ce3, oe3, we3;

  logic [3:0] h3 [1:6];

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  data_memory_bus_ctrl #(
    .NUM_SRAM    (2),
    .SRAM_WAIT   (1),
    .PERIPH_WAIT (0)
  ) dut (
    .clk            (clk),
    .RESET          (RESET),
    .req            (req),
    .address        (address),
    .read           (read),
    .write          (write),
    .ready          (ready),
    .err            (err),
    .busy           (busy),
    .CE             (ce),
    .OE             (oe),
    .WE             (we),
    .Control_Module (cm),
    .UART1          (ua)
  );

  data_memory_bus_ctrl #(
    .NUM_SRAM    (3),
    .SRAM_WAIT   (1),
    .PERIPH_WAIT (0)
  ) dut3 (
    .clk            (clk),
    .RESET          (RESET),
    .req            (req),
    .address        (address),
    .read           (read),
    .write          (write),
    .ready          (ready3),
    .err            (err3),
    .busy           (busy3),
    .CE             (ce3),
    .OE             (oe3),
    .WE             (we3),
    .Control_Module (cm3),
    .UART1          (ua3)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h",
                  tag, got, exp);
  endtask

  // {CE,OE,WE,cm,ua,ready,err,busy}
  function automatic logic [10:0] snap();
    return {ce, oe, we, cm, ua, ready, err, busy};
  endfunction

  // kind: 0 error, 1 SRAM, 2 Control Module, 3 UART1
  function automatic logic [10:0] expv(input int kind,
                                       input int bank,
                                       input bit wr,
                                       input int w,
                                       input int k);
    logic [10:0] v;
    logic [1:0]  oh;
    bit          sel, stb;
    v  = '0;
    oh = (bank == 0) ? 2'b01 : 2'b10;
    if (kind == 0) begin
      if (k == 1) v = 11'h007;
      return v;
    end
    sel = (k >= 1) && (k <= 2 + w);
    stb = (k >= 2) && (k <= 2 + w);
    if (kind == 1 && sel)         v[10:9] = oh;
    if (kind == 1 && stb && !wr)  v[8:7]  = oh;
    if (kind == 1 && stb && wr)   v[6:5]  = oh;
    if (kind == 2 && sel)         v[4]    = 1'b1;
    if (kind == 3 && sel)         v[3]    = 1'b1;
    if (k == 3 + w)               v[2]    = 1'b1;
    if (k >= 1 && k <= 3 + w)     v[0]    = 1'b1;
    return v;
  endfunction

  task automatic txn(input string tag,
                     input logic [31:0] a,
                     input bit rd, input bit wr,
                     input int kind, input int bank,
                     input int w, input bit toggle);
    @(negedge clk);
    req = 1'b1; address = a; read = rd; write = wr;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      check($sformatf("%s_c%0d", tag, k), 32'(snap()),
            32'(expv(kind, bank, wr, w, k)));
      h3[k] = {ce3, ready3};
      req = 1'b0;
      if (toggle && k == 1) begin
        req = 1'b1; address = 32'h1000_0000;
        read = 1'b1; write = 1'b0;
      end
      if (toggle && k == 2) begin
        address = 32'h4802_2000; read = 1'b0; write = 1'b1;
      end
    end
    read = 1'b0; write = 1'b0;
  endtask

  initial begin
    bit seen;
    RESET = 1'b1; req = 1'b0; address = '0;
    read = 1'b0; write = 1'b0;
    repeat (2) @(negedge clk);
    check("reset", 32'(snap()), 32'h0);
    check("reset3", 32'({ce3, oe3, we3, ready3, busy3}), 32'h0);
    RESET = 1'b0;

    txn("rd_b0",   32'h1000_08AD, 1, 0, 1, 0, 1, 0);
    txn("wr_b1",   32'h1400_0F32, 0, 1, 1, 1, 1, 1);
    txn("err_lo",  32'h2000_0FFA, 1, 0, 0, 0, 0, 0);
    txn("err_cm",  32'h44E1_28AD, 1, 0, 0, 0, 0, 0);
    txn("err_rw",  32'h1000_0000, 1, 1, 0, 0, 0, 0);
    txn("err_nop", 32'h1000_0000, 0, 0, 0, 0, 0, 0);
    txn("rd_cm",   32'h44E1_0ABC, 1, 0, 2, 0, 0, 0);
    txn("wr_ua",   32'h4802_2C58, 0, 1, 3, 0, 0, 0);
    txn("err_ua",  32'h4802_3BBB, 1, 0, 0, 0, 0, 0);
    txn("top_b1",  32'h17FF_FFFF, 1, 0, 1, 1, 1, 0);
    txn("err_b2",  32'h1800_0000, 1, 0, 0, 0, 0, 0);
    check("b2_n3_c1", 32'(h3[1]), 32'h8);
    check("b2_n3_c3", 32'(h3[3]), 32'h8);
    check("b2_n3_c4", 32'(h3[4]), 32'h1);
    txn("err_below", 32'h0FFF_FFFF, 1, 0, 0, 0, 0, 0);

    @(negedge clk);
    req = 1'b1; address = 32'h1000_0000; read = 1'b1;
    @(negedge clk);
    req = 1'b0;
    @(negedge clk);
    check("rst_pre", 32'(snap()), 32'(expv(1, 0, 0, 1, 2)));
    #1 RESET = 1'b1;
    #1 check("rst_async", 32'(snap()), 32'h0);
    @(negedge clk);
    check("rst_hold", 32'(snap()), 32'h0);
    RESET = 1'b0; read = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      seen = seen | ready | busy;
    end
    check("rst_noready", 32'(seen), 32'h0);
    txn("after_rst", 32'h1000_0000, 1, 0, 1, 0, 1, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/data_memory_bus_ctrl.md
# data_memory_bus_ctrl

Parametrised data-memory bus controller for the soft-core data port. It decodes a 32-bit address into N SRAM banks, the Control Module window or the UART1 window, and runs a registered request/ready transaction. Each transaction asserts chip-enable, output-enable or write-enable strobes, with a configurable number of wait states per region. Accesses to unmapped addresses, or with an illegal read+write request, complete with an error response and drive no strobes.

## Interface
- AW, 32, address width
- NUM_SRAM, 2, number of SRAM banks (1..8), contiguous from SRAM_BASE
- SRAM_BASE, 32'h1000_0000, base of SRAM bank 0
- SRAM_SIZE_LOG2, 26, log2 bytes per bank (64 MiB; bank1 = 0x1400_0000)
- CTRL_BASE / CTRL_SIZE_LOG2, 32'h44E1_0000 / 13, Control Module window (to 0x44E1_1FFF)
- UART_BASE / UART_SIZE_LOG2, 32'h4802_2000 / 12, UART1 window (to 0x4802_2FFF)
- SRAM_WAIT, 1, extra STROBE cycles for SRAM (0..15)
- PERIPH_WAIT, 0, extra STROBE cycles for peripherals (0..15)

Ports:
- clk  in  1  system clock, rising edge
- RESET  in  1  asynchronous, active-high reset
- req  in  1  transaction request, sampled in IDLE only
- address  in  AW  byte address, latched on acceptance
- read  in  1  read request, latched on acceptance
- write  in  1  write request, latched on acceptance
- ready  out  1  one-cycle completion pulse
- err  out  1  error flag, valid only while ready=1
- busy  out  1  high from acceptance through the ready cycle
- CE  out  NUM_SRAM  per-bank chip enable (active-high)
- OE  out  NUM_SRAM  per-bank output enable (active-high)
- WE  out  NUM_SRAM  per-bank write enable (active-high)
- Control_Module  out  1  Control Module select
- UART1  out  1  UART1 select

## Operation
- FSM states: IDLE, SETUP, STROBE, DONE, ERROR.
- IDLE, req=0: stay in IDLE.
- IDLE, req=1, exactly one of read/write high, address mapped: latch address, op and region; go to SETUP.
- IDLE, req=1, otherwise (unmapped address, read=write=1, or read=write=0): go to ERROR.
- SETUP: the selected CE bit or peripheral select is high; OE/WE are low. Wait counter loads with the region's wait value. Next state is STROBE.
- STROBE: select stays high, and OE (read) or WE (write) of the selected bank is high. Peripherals drive only their select. Stay while counter ≠ 0, decrementing each cycle; at 0 go to DONE.
- DONE: ready=1, err=0, all strobes 0. Next state is IDLE.
- ERROR: ready=1, err=1, no strobe ever asserted. Next state is IDLE.
- Decode uses aligned base compare: region hit ⇔ address[AW-1:SIZE_LOG2] == BASE[AW-1:SIZE_LOG2].
- SRAM bank index = (address − SRAM_BASE) >> SRAM_SIZE_LOG2. It is valid only when the index < NUM_SRAM; beyond the top bank the address is unmapped.
- Changes on address, read or write after acceptance are ignored. req while busy=1 is ignored and is not queued.
- At most one select or CE bit is high in any cycle.

## Timing
- All outputs are registered, and every output is reset to 0.
- RESET takes effect asynchronously: all outputs drop to 0 without waiting for an edge, and the FSM enters IDLE. This applies mid-transaction as well; the aborted transaction produces no ready.
- Let E0 be the edge that samples req=1 in IDLE.
  - SETUP is cycle 1. STROBE covers cycles 2..2+W, where W is the region's wait value. DONE is cycle 3+W.
  - An SRAM access with W=1 completes with ready in cycle 4.
  - An error access completes with ready=err=1 in cycle 1.
- After ready the FSM is in IDLE for the following cycle, and a new req may be sampled at the edge ending that cycle. Back-to-back period is 4+W cycles.

## Structure
- Shared package dmem_map_pkg holds:
  - region enum {REG_NONE, REG_SRAM, REG_CTRL, REG_UART}
  - FSM state enum
  - default base and size constants for the memory map, so that ProgramAddressMap and future decoders use the same values
- Sub-module dmem_region_decode: combinational address → {region, bank index, hit}, parametrised identically. The top level holds the FSM, the wait counter, latches and output registers.

## Test plan
- NUM_SRAM=2, SRAM_WAIT=1: read 0x1000_08AD → CE[0]=1 in cycles 1–3, OE[0]=1 in cycles 2–3, ready=1 and err=0 in cycle 4; CE[1], WE and both peripheral selects stay 0.
- Write 0x1400_0F32 → CE[1] in cycles 1–3, WE[1] in cycles 2–3, ready in cycle 4; OE stays 0. Toggling address mid-transaction changes nothing.
- Error cases: read at 0x2000_0FFA, read at 0x44E1_28AD, and req with read=write=1 at 0x1000_0000 → ready=err=1 in cycle 1, no strobes, busy only in cycle 1.
- PERIPH_WAIT=0: read 0x44E1_0ABC → Control_Module=1 in cycles 1–2, ready in cycle 3. Write 0x4802_2C58 → UART1 with the same timing. 0x4802_3BBB → err.
- Bank boundaries:
  - 0x17FF_FFFF → CE[1].
  - 0x1800_0000 → err with NUM_SRAM=2; CE[2] with NUM_SRAM=3.
  - 0x0FFF_FFFF → err.
- RESET pulsed in STROBE of an SRAM read → CE/OE/busy fall to 0 without a clock edge, and no ready is produced. After release, a read of 0x1000_0000 completes normally in cycle 4.
